sdft_sequencer: RTL and testbench
=================================

SDFT_SEQUENCER -- requirements
Module: sdft_sequencer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16: sample and sample-difference width.
REQ-002 SHALL have parameter FFT_SIZE, default 512: bin count; power of two, at least 8.
REQ-003 SHALL have parameter SPU_LATENCY, default 3: update-unit pipeline depth in cycles.
REQ-004 SHALL have parameter DISP_DECIM, default 16: sweeps per display write; at least 1.
REQ-005 SHALL have port clk  in  1: the single clock.
REQ-006 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-007 SHALL have port i_sample_valid  in  1: new sample offered.
REQ-008 SHALL have port o_sample_ready  out  1: sample accepted when valid and ready are both high.
REQ-009 SHALL have port i_sample  in  WORD_WIDTH (signed): newest sample.
REQ-010 SHALL have port i_oldest  in  WORD_WIDTH (signed): sample leaving the window.
REQ-011 SHALL have port o_rd_addr  out  clog2(FFT_SIZE): bin-RAM and twiddle-ROM read address.
REQ-012 SHALL have port o_idx  out  clog2(FFT_SIZE): bin index to the update unit.
REQ-013 SHALL have port o_sample_diff  out  WORD_WIDTH (signed): difference to the update unit.
REQ-014 SHALL have port o_wr_en  out  1: bin write-enable to the update unit.
REQ-015 SHALL have port o_disp_wr_en  out  1: display write-enable to the update unit.
REQ-016 SHALL have port o_busy  out  1: sweep in progress.
REQ-017 SHALL have port o_sweep_done  out  1: one-cycle pulse per completed sweep.

Function
REQ-018 SHALL implement states IDLE, SWEEP and DRAIN, with o_sample_ready=1 only in IDLE (see REQ-031).
REQ-019 On accept, SHALL latch the diff, saturated to WORD_WIDTH: (i_sample - i_oldest) computed in WORD_WIDTH+1 bits, clamped to [-2^(W-1), 2^(W-1)-1].
REQ-020 On accept, SHALL enter SWEEP and drive o_rd_addr=0, 1, ..., FFT_SIZE-1 on consecutive cycles, with no gaps.
REQ-021 SHALL drive o_idx=k with o_wr_en=1 and the latched o_sample_diff exactly one cycle after o_rd_addr=k, matching the one-cycle read latency of the RAM and ROM.
REQ-022 SHALL drive o_disp_wr_en equal to o_wr_en during display sweeps, and 0 otherwise.
REQ-023 A display sweep SHALL be one where the decimation counter equals DISP_DECIM-1.
REQ-024 The decimation counter SHALL increment once per sweep at sweep end, wrapping DISP_DECIM-1 to 0.
REQ-025 After o_rd_addr=FFT_SIZE-1, SHALL enter DRAIN for SPU_LATENCY+1 cycles, then return to IDLE.
REQ-026 SHALL pulse o_sweep_done exactly SPU_LATENCY cycles after the cycle with o_idx=FFT_SIZE-1 and o_wr_en=1.
REQ-027 o_busy SHALL be 1 in SWEEP and DRAIN, and 0 in IDLE.
REQ-028 i_sample_valid outside IDLE SHALL be ignored; the upstream holds the sample until ready.
REQ-029 When o_wr_en=0, SHALL hold o_idx, o_rd_addr and o_sample_diff at their last values.

Reset
REQ-030 reset_n low, at any time including mid-sweep, SHALL force IDLE with:
- o_sample_ready=1;
- all other outputs 0;
- the decimation counter 0;
- the o_sweep_done delay line cleared.
Bin RAM contents are not cleared by this block.

Configuration
REQ-031 With SDFT_SEQ_OVERLAP_EN defined, SHALL also assert o_sample_ready in the SWEEP cycle where o_rd_addr=FFT_SIZE-1.
- An accept in that cycle SHALL start the next sweep with o_rd_addr=0 on the following cycle, skipping DRAIN.
- o_sweep_done timing SHALL be unchanged.
REQ-032 Without SDFT_SEQ_OVERLAP_EN, the behaviour SHALL be exactly that of REQ-018 and REQ-025.

Structure
REQ-033 Shared package stft_pkg SHALL hold the state encoding and the SPU_LATENCY default constant.
REQ-034 The o_sweep_done delay SHALL reuse the team's buffer module; there are no other sub-modules.

Verification
Bench settings: FFT_SIZE=8, SPU_LATENCY=3, DISP_DECIM=2 unless stated.
REQ-035 Single sample i_sample=100, i_oldest=40, accepted at cycle 0:
- o_rd_addr 0..7 in cycles 1-8;
- o_idx 0..7 with o_sample_diff=60 in cycles 2-9;
- o_sweep_done in cycle 12;
- ready again in cycle 13.
REQ-036 Saturation, WORD_WIDTH=16:
- 32767 - (-5) -> o_sample_diff=32767;
- -32768 - 1 -> o_sample_diff=-32768.
REQ-037 Four back-to-back samples -> o_disp_wr_en high only on sweeps 2 and 4.
REQ-038 reset_n pulsed low at o_idx=4 -> all outputs 0 immediately; the next accepted sample restarts at o_rd_addr=0 with a non-display sweep.
REQ-039 With SDFT_SEQ_OVERLAP_EN, valid held high -> o_rd_addr runs 0..7, 0..7 with no idle cycle, and o_sweep_done pulses 8 cycles apart.
REQ-040 Valid asserted during DRAIN without the macro -> not accepted until IDLE; the sample is taken exactly once.

Source files
------------

// File: rtl/stft_pkg.sv
// stft_pkg: state encoding and default constants shared by the sliding-DFT pipeline blocks.
package stft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    localparam int SPU_LATENCY_DEFAULT = 3;

endpackage

// File: rtl/sdft_sequencer_buffer.sv
// sdft_sequencer_buffer: fixed-depth shift-register delay line, cleared by the asynchronous reset.
module sdft_sequencer_buffer #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/sdft_sequencer.sv
// sdft_sequencer: runs one full bin-update sweep per accepted sample for a sliding DFT.
// Define SDFT_SEQ_OVERLAP_EN to accept the next sample on the last read of a sweep.
module sdft_sequencer
    import stft_pkg::*;
#(
    parameter int WORD_WIDTH  = 16,
    parameter int FFT_SIZE    = 512,
    parameter int SPU_LATENCY = SPU_LATENCY_DEFAULT,
    parameter int DISP_DECIM  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_sample_valid,
    output logic                          o_sample_ready,
    input  logic signed [WORD_WIDTH-1:0]  i_sample,
    input  logic signed [WORD_WIDTH-1:0]  i_oldest,
    output logic [$clog2(FFT_SIZE)-1:0]   o_rd_addr,
    output logic [$clog2(FFT_SIZE)-1:0]   o_idx,
    output logic signed [WORD_WIDTH-1:0]  o_sample_diff,
    output logic                          o_wr_en,
    output logic                          o_disp_wr_en,
    output logic                          o_busy,
    output logic                          o_sweep_done
);

    localparam int AW = $clog2(FFT_SIZE);
    localparam int DW = (DISP_DECIM > 1) ? $clog2(DISP_DECIM) : 1;
    localparam int CW = $clog2(SPU_LATENCY + 2);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(FFT_SIZE - 1);
    localparam logic [DW-1:0] LAST_DEC   = DW'(DISP_DECIM - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(SPU_LATENCY);
`ifdef SDFT_SEQ_OVERLAP_EN
    localparam bit OVERLAP_EN = 1'b1;
`else
    localparam bit OVERLAP_EN = 1'b0;
`endif

    seq_state_t state, state_next;

    logic                         accept;
    logic                         sweep_last;
    logic                         drain_last;
    logic                         last_write;
    logic [DW-1:0]                dec_cnt;
    logic [CW-1:0]                drain_cnt;
    logic signed [WORD_WIDTH:0]   diff_wide;
    logic signed [WORD_WIDTH-1:0] diff_sat;
    logic signed [WORD_WIDTH-1:0] diff_q;

    assign accept     = i_sample_valid && o_sample_ready;
    assign sweep_last = (state == ST_SWEEP) && (o_rd_addr == LAST_ADDR);
    assign drain_last = (state == ST_DRAIN) && (drain_cnt == LAST_DRAIN);
    assign last_write = o_wr_en && (o_idx == LAST_ADDR);

    // One guard bit catches overflow; disagreeing top bits mean clamp toward the guard's sign.
    assign diff_wide = {i_sample[WORD_WIDTH-1], i_sample} - {i_oldest[WORD_WIDTH-1], i_oldest};

    always_comb begin
        diff_sat = diff_wide[WORD_WIDTH-1:0];
        if (diff_wide[WORD_WIDTH] != diff_wide[WORD_WIDTH-1])
            diff_sat = diff_wide[WORD_WIDTH] ? {1'b1, {(WORD_WIDTH-1){1'b0}}}
                                             : {1'b0, {(WORD_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_SWEEP;
            ST_SWEEP: if (sweep_last && !accept) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_sample_ready = (state == ST_IDLE) || (OVERLAP_EN && sweep_last);
        o_busy         = (state != ST_IDLE);
    end

    // Write stage trails the read address by one cycle to line up with RAM/ROM read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            diff_q        <= '0;
            o_rd_addr     <= '0;
            o_idx         <= '0;
            o_sample_diff <= '0;
            o_wr_en       <= 1'b0;
            o_disp_wr_en  <= 1'b0;
            dec_cnt       <= '0;
            drain_cnt     <= '0;
        end else begin
            if (accept) begin
                diff_q    <= diff_sat;
                o_rd_addr <= '0;
            end else if ((state == ST_SWEEP) && !sweep_last) begin
                o_rd_addr <= o_rd_addr + 1'b1;
            end

            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;

            if (sweep_last)
                dec_cnt <= (dec_cnt == LAST_DEC) ? '0 : dec_cnt + 1'b1;

            o_wr_en      <= (state == ST_SWEEP);
            o_disp_wr_en <= (state == ST_SWEEP) && (dec_cnt == LAST_DEC);
            if (state == ST_SWEEP) begin
                o_idx         <= o_rd_addr;
                o_sample_diff <= diff_q;
            end
        end
    end

    sdft_sequencer_buffer #(
        .WIDTH (1),
        .DEPTH (SPU_LATENCY)
    ) u_done_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (last_write),
        .q       (o_sweep_done)
    );

endmodule

// File: tb/tb_sdft_sequencer.sv
// tb_sdft_sequencer: directed bench with a write scoreboard for sdft_sequencer (FFT_SIZE=8, latency 3, decimation 2).
module tb_sdft_sequencer;

    localparam int WORD_WIDTH  = 16;
    localparam int FFT_SIZE    = 8;
    localparam int SPU_LATENCY = 3;
    localparam int DISP_DECIM  = 2;
    localparam int AW          = 3;
`ifdef SDFT_SEQ_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0]                idx;
        logic signed [WORD_WIDTH-1:0] diff;
        logic                         disp;
    } wr_exp_t;

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic                         i_sample_valid;
    logic                         o_sample_ready;
    logic signed [WORD_WIDTH-1:0] i_sample;
    logic signed [WORD_WIDTH-1:0] i_oldest;
    logic [AW-1:0]                o_rd_addr;
    logic [AW-1:0]                o_idx;
    logic signed [WORD_WIDTH-1:0] o_sample_diff;
    logic                         o_wr_en;
    logic                         o_disp_wr_en;
    logic                         o_busy;
    logic                         o_sweep_done;

    wr_exp_t exp_q[$];
    int      sweeps_started = 0;
    int      disp_writes    = 0;
    int      checks_total   = 0;
    int      checks_passed  = 0;
    int      checks_failed  = 0;

    always #5 clk = ~clk;

    sdft_sequencer #(
        .WORD_WIDTH  (WORD_WIDTH),
        .FFT_SIZE    (FFT_SIZE),
        .SPU_LATENCY (SPU_LATENCY),
        .DISP_DECIM  (DISP_DECIM)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_sample_valid (i_sample_valid),
        .o_sample_ready (o_sample_ready),
        .i_sample       (i_sample),
        .i_oldest       (i_oldest),
        .o_rd_addr      (o_rd_addr),
        .o_idx          (o_idx),
        .o_sample_diff  (o_sample_diff),
        .o_wr_en        (o_wr_en),
        .o_disp_wr_en   (o_disp_wr_en),
        .o_busy         (o_busy),
        .o_sweep_done   (o_sweep_done)
    );

    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: saturated difference and display flag derived from sweeps started since reset.
    task automatic push_sweep(input int sample, input int oldest);
        int      d;
        wr_exp_t e;
        d = sample - oldest;
        if (d > 32767) d = 32767;
        else if (d < -32768) d = -32768;
        for (int k = 0; k < FFT_SIZE; k++) begin
            e.idx  = AW'(k);
            e.diff = d[WORD_WIDTH-1:0];
            e.disp = ((sweeps_started % DISP_DECIM) == DISP_DECIM - 1);
            exp_q.push_back(e);
        end
        sweeps_started++;
    endtask

    task automatic monitor_writes();
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (o_disp_wr_en) disp_writes++;
            if (o_wr_en) begin
                if (exp_q.size() == 0) begin
                    check_output("wr_unexpected", {31'b0, o_wr_en}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("sb_idx", o_idx, e.idx);
                    check_output("sb_diff", o_sample_diff, e.diff);
                    check_output("sb_disp", o_disp_wr_en, e.disp);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        i_sample_valid = 1'b0;
        exp_q.delete();
        sweeps_started = 0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // Offers a sample, waits (bounded) for ready, and returns in the cycle after the accept.
    task automatic apply_stimulus(input int sample, input int oldest);
        int waited;
        i_sample       = sample[WORD_WIDTH-1:0];
        i_oldest       = oldest[WORD_WIDTH-1:0];
        i_sample_valid = 1'b1;
        waited = 0;
        while (!o_sample_ready && waited < 64) begin
            step();
            waited++;
        end
        check_output("accept_ready", o_sample_ready, 1);
        push_sweep(sample, oldest);
        step();
        i_sample_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (o_busy && waited < 200) begin
            step();
            waited++;
        end
        check_output("idle_timeout", o_busy, 0);
    endtask

    initial begin
        int disp_before;
        int waited;
        reset_n        = 1'b0;
        i_sample_valid = 1'b0;
        i_sample       = '0;
        i_oldest       = '0;
        fork
            monitor_writes();
        join_none
        step();
        step();
        check_output("rst_ready", o_sample_ready, 1);
        check_output("rst_busy", o_busy, 0);
        check_output("rst_rd_addr", o_rd_addr, 0);
        check_output("rst_idx", o_idx, 0);
        check_output("rst_wr_en", o_wr_en, 0);
        check_output("rst_disp", o_disp_wr_en, 0);
        check_output("rst_done", o_sweep_done, 0);
        reset_n = 1'b1;
        step();

        $display("[TB] single sample timing");
        apply_stimulus(100, 40);
        for (int c = 1; c <= 13; c++) begin
            if (c <= 8) check_output("t1_rd_addr", o_rd_addr, c - 1);
            check_output("t1_wr_en", o_wr_en, (c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) begin
                check_output("t1_idx", o_idx, c - 2);
                check_output("t1_diff", o_sample_diff, 60);
            end
            check_output("t1_done", o_sweep_done, (c == 12));
            check_output("t1_ready", o_sample_ready, (c == 13) || (OVERLAP && c == 8));
            check_output("t1_busy", o_busy, (c <= 12));
            step();
        end

        $display("[TB] saturation");
        do_reset();
        apply_stimulus(32767, -5);
        apply_stimulus(-32768, 1);
        wait_idle();

        $display("[TB] display decimation over four sweeps");
        do_reset();
        disp_before = disp_writes;
        apply_stimulus(1000, 1);
        apply_stimulus(-200, 300);
        apply_stimulus(5, 5);
        apply_stimulus(-7, 9);
        wait_idle();
        step();
        check_output("disp_count", disp_writes - disp_before, 2 * FFT_SIZE);

        $display("[TB] reset mid-sweep");
        do_reset();
        apply_stimulus(500, 200);
        waited = 0;
        while (!(o_wr_en && o_idx == 3'd4) && waited < 32) begin
            step();
            waited++;
        end
        check_output("mid_idx_reached", o_idx, 4);
        reset_n = 1'b0;
        exp_q.delete();
        sweeps_started = 0;
        #1;
        check_output("mid_ready", o_sample_ready, 1);
        check_output("mid_busy", o_busy, 0);
        check_output("mid_rd_addr", o_rd_addr, 0);
        check_output("mid_idx", o_idx, 0);
        check_output("mid_diff", o_sample_diff, 0);
        check_output("mid_wr_en", o_wr_en, 0);
        check_output("mid_disp", o_disp_wr_en, 0);
        check_output("mid_done", o_sweep_done, 0);
        step();
        reset_n = 1'b1;
        step();
        apply_stimulus(7, 3);
        check_output("restart_rd_addr", o_rd_addr, 0);
        check_output("restart_busy", o_busy, 1);
        step();
        check_output("restart_wr_en", o_wr_en, 1);
        check_output("restart_disp", o_disp_wr_en, 0);
        wait_idle();

`ifdef SDFT_SEQ_OVERLAP_EN
        $display("[TB] overlapped sweeps with valid held high");
        do_reset();
        i_sample       = 16'sd10;
        i_oldest       = 16'sd4;
        i_sample_valid = 1'b1;
        check_output("ovl_ready", o_sample_ready, 1);
        push_sweep(10, 4);
        step();
        for (int c = 1; c <= 21; c++) begin
            if (c <= 16) check_output("ovl_rd_addr", o_rd_addr, (c - 1) % FFT_SIZE);
            check_output("ovl_done", o_sweep_done, (c == 12) || (c == 20));
            if (c == 8) push_sweep(10, 4);
            if (c == 16) i_sample_valid = 1'b0;
            step();
        end
        wait_idle();
`else
        $display("[TB] valid raised during drain");
        do_reset();
        apply_stimulus(20, 5);
        repeat (9) step();
        i_sample       = 16'sd9;
        i_oldest       = 16'sd1;
        i_sample_valid = 1'b1;
        for (int c = 10; c <= 13; c++) begin
            check_output("drain_ready", o_sample_ready, (c == 13));
            check_output("drain_busy", o_busy, (c <= 12));
            step();
        end
        check_output("drain_rd_addr", o_rd_addr, 0);
        check_output("drain_busy_after", o_busy, 1);
        i_sample_valid = 1'b0;
        push_sweep(9, 1);
        wait_idle();
        repeat (3) begin
            step();
            check_output("drain_single_take", o_busy, 0);
        end
`endif

        step();
        check_output("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
